// File: rtl/lc4_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc4_trace_pkg
// Brief    : Shared constants, record layout and helpers for the LC4 trace recorder.
// Revision : 1.0
// ============================================================================
package lc4_trace_pkg;

    localparam logic [1:0] STALL_EXEC   = 2'd0;
    localparam logic [1:0] STALL_CACHE  = 2'd1;
    localparam logic [1:0] STALL_BRANCH = 2'd2;
    localparam logic [1:0] STALL_LOAD   = 2'd3;

    localparam int BEAT_W    = 16;
    localparam int HDR_BEATS = 4;

    localparam int BEAT_PC    = 0;
    localparam int BEAT_INSN  = 1;
    localparam int BEAT_FLAGS = 2;
    localparam int BEAT_DADDR = 3;

    // Beat i of a record lives at bits [i*BEAT_W +: BEAT_W].
    localparam int OFF_PC    = BEAT_PC    * BEAT_W;
    localparam int OFF_INSN  = BEAT_INSN  * BEAT_W;
    localparam int OFF_FLAGS = BEAT_FLAGS * BEAT_W;
    localparam int OFF_DADDR = BEAT_DADDR * BEAT_W;
    localparam int OFF_RDATA = HDR_BEATS  * BEAT_W;

    function automatic int rec_beats(input int word_size);
        return HDR_BEATS + 2 * (word_size / BEAT_W);
    endfunction

    function automatic int off_dmem_data(input int word_size);
        return OFF_RDATA + word_size;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/lc4_trace_recorder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lc4_trace_fifo
// Brief    : Single-clock FIFO of packed trace records with first-word head view.
// Revision : 1.0
// ============================================================================
module lc4_trace_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_q, w_wr_d;
    logic [c_PTR_W-1:0] r_rd_q, w_rd_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;

    always_comb begin
        w_wr_d  = r_wr_q;
        w_rd_d  = r_rd_q;
        w_cnt_d = r_cnt_q;
        if (i_push) w_wr_d = r_wr_q + c_PTR_W'(1);
        if (i_pop)  w_rd_d = r_rd_q + c_PTR_W'(1);
        case ({i_push, i_pop})
            2'b10:   w_cnt_d = r_cnt_q + c_CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt_q - c_CNT_W'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_q  <= '0;
            r_rd_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            r_wr_q  <= w_wr_d;
            r_rd_q  <= w_rd_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    // A push while full is only issued alongside a pop, so the slot being
    // written is the one whose last beat has just been consumed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem_q[r_wr_q] <= i_data;
    end

    assign o_head  = r_mem_q[r_rd_q];
    assign o_full  = (r_cnt_q == c_CNT_W'(DEPTH));
    assign o_empty = (r_cnt_q == '0);
    assign o_count = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/lc4_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : lc4_trace_recorder
// Brief    : Captures LC4 commit records, buffers them and streams 16-bit beats.
// Revision : 1.0
// ============================================================================
module lc4_trace_recorder
    import lc4_trace_pkg::*;
#(
    parameter int WORD_SIZE  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 enable,
    input  logic [1:0]           test_stall,
    input  logic [15:0]          test_cur_pc,
    input  logic [15:0]          test_cur_insn,
    input  logic                 test_regfile_we,
    input  logic [2:0]           test_regfile_wsel,
    input  logic [WORD_SIZE-1:0] test_regfile_data,
    input  logic                 test_nzp_we,
    input  logic [2:0]           test_nzp_new_bits,
    input  logic                 test_dmem_we,
    input  logic [15:0]          test_dmem_addr,
    input  logic [WORD_SIZE-1:0] test_dmem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic                 out_last,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic [31:0]          cnt_exec,
    output logic [31:0]          cnt_cache,
    output logic [31:0]          cnt_branch,
    output logic [31:0]          cnt_load
);

    localparam int c_N         = rec_beats(WORD_SIZE);
    localparam int c_REC_W     = c_N * BEAT_W;
    localparam int c_IDX_W     = $clog2(c_N);
    localparam int c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int c_OFF_DDATA = off_dmem_data(WORD_SIZE);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    ser_state_e         r_state_q, w_state_d;
    logic [c_IDX_W-1:0] r_idx_q, w_idx_d;
    logic               r_ovf_q, w_ovf_d;
    logic [15:0]        r_drop_q, w_drop_d;
    logic [31:0]        r_cnt_q [4];
    logic [31:0]        w_cnt_d [4];

    logic [c_REC_W-1:0] w_record;
    logic [c_REC_W-1:0] w_head;
    logic [BEAT_W-1:0]  w_beats [c_N];
    logic               w_capture, w_xfer, w_pop, w_push;
    logic               w_full, w_empty;
    logic [c_CNT_W-1:0] w_count;

    always_comb begin
        w_record = '0;
        w_record[OFF_PC    +: BEAT_W]    = test_cur_pc;
        w_record[OFF_INSN  +: BEAT_W]    = test_cur_insn;
        w_record[OFF_FLAGS +: BEAT_W]    = {test_regfile_we, test_regfile_wsel,
                                            test_nzp_we, test_nzp_new_bits,
                                            test_dmem_we, 7'b0};
        w_record[OFF_DADDR +: BEAT_W]    = test_dmem_addr;
        w_record[OFF_RDATA +: WORD_SIZE] = test_regfile_data;
        w_record[c_OFF_DDATA +: WORD_SIZE] = test_dmem_data;
    end

    assign w_capture = gwe && enable && (test_stall == STALL_EXEC);
    assign w_xfer    = (r_state_q == ST_SEND) && out_ready;
    assign w_pop     = w_xfer && (r_idx_q == c_LAST);
    assign w_push    = w_capture && (!w_full || w_pop);

    lc4_trace_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_record),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    for (genvar g = 0; g < c_N; g++) begin : g_beats
        assign w_beats[g] = w_head[g*BEAT_W +: BEAT_W];
    end

    always_comb begin
        w_idx_d = r_idx_q;
        if (w_xfer) w_idx_d = (r_idx_q == c_LAST) ? '0 : r_idx_q + c_IDX_W'(1);

        // Stay in SEND whenever anything is left after this edge: no bubble.
        w_state_d = (w_push || (!w_empty && !(w_pop && w_count == c_CNT_W'(1))))
                    ? ST_SEND : ST_IDLE;

        w_ovf_d  = r_ovf_q;
        w_drop_d = r_drop_q;
        if (w_capture && !w_push) begin
            w_ovf_d = 1'b1;
            if (r_drop_q != 16'hFFFF) w_drop_d = r_drop_q + 16'd1;
        end

        for (int i = 0; i < 4; i++) w_cnt_d[i] = r_cnt_q[i];
        if (gwe && r_cnt_q[test_stall] != 32'hFFFF_FFFF)
            w_cnt_d[test_stall] = r_cnt_q[test_stall] + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_drop_q  <= '0;
            for (int i = 0; i < 4; i++) r_cnt_q[i] <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_ovf_q   <= w_ovf_d;
            r_drop_q  <= w_drop_d;
            for (int i = 0; i < 4; i++) r_cnt_q[i] <= w_cnt_d[i];
        end
    end

    assign out_valid  = (r_state_q == ST_SEND);
    assign out_last   = out_valid && (r_idx_q == c_LAST);
    assign out_data   = out_valid ? w_beats[r_idx_q] : '0;
    assign overflow   = r_ovf_q;
    assign drop_count = r_drop_q;
    assign cnt_exec   = r_cnt_q[STALL_EXEC];
    assign cnt_cache  = r_cnt_q[STALL_CACHE];
    assign cnt_branch = r_cnt_q[STALL_BRANCH];
    assign cnt_load   = r_cnt_q[STALL_LOAD];

endmodule
`default_nettype wire
